i2s_transmitter: RTL

I2S_TRANSMITTER -- requirements
Module: i2s_transmitter

---
 rtl/i2s_transmitter.sv | 103 ++++++++++
 1 files changed

// File: rtl/i2s_transmitter.sv
// I2S serializer: stages a left/right pair from the limiter and ships it in a 64-BCLK frame.
// Latency: outputs lag the div/bit counters by one clk; a complete pair goes out in the next frame. No back-pressure.
module i2s_transmitter #(
    parameter int WIDTH    = 24,
    parameter int BCLK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] lim_d,
    input  logic             lim_ch,
    input  logic             lim_dv,
    output logic             i2s_bclk,
    output logic             i2s_lrclk,
    output logic             i2s_sd,
    output logic             frame_sync,
    output logic             underrun
);

    localparam int DW = $clog2(BCLK_DIV);

    logic [DW-1:0]    div_cnt;
    logic [5:0]       bit_cnt;
    logic [WIDTH-1:0] stage_l, stage_r, tx_l, tx_r;
    logic             vld_l, vld_r;
    logic             tail_bit;

    logic        div_wrap, frame_end, pair_ok;
    logic [5:0]  j;
    logic [31:0] slot, r_aligned;
    logic        sd_next;

    assign div_wrap  = (div_cnt == DW'(BCLK_DIV - 1));
    assign frame_end = div_wrap && (bit_cnt == 6'd63);
    assign pair_ok   = vld_l && vld_r;
    assign j         = bit_cnt - 6'd1;

    // Words are left-aligned into a 32-bit slot so bits past WIDTH read as zero padding.
    assign r_aligned = 32'(tx_r) << (32 - WIDTH);

    always_comb begin
        slot    = (j[5] ? 32'(tx_r) : 32'(tx_l)) << (32 - WIDTH);
        sd_next = slot[5'd31 - j[4:0]];
        // With WIDTH = 32 the right LSB spills into bit 0 of the next frame, after tx_r has reloaded.
        if (bit_cnt == 6'd0) begin
            sd_next = tail_bit;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt    <= '0;
            bit_cnt    <= '0;
            stage_l    <= '0;
            stage_r    <= '0;
            vld_l      <= 1'b0;
            vld_r      <= 1'b0;
            tx_l       <= '0;
            tx_r       <= '0;
            tail_bit   <= 1'b0;
            i2s_bclk   <= 1'b0;
            i2s_lrclk  <= 1'b0;
            i2s_sd     <= 1'b0;
            frame_sync <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
            if (div_wrap) begin
                bit_cnt <= bit_cnt + 6'd1;
            end

            i2s_bclk   <= (div_cnt >= DW'(BCLK_DIV / 2));
            i2s_lrclk  <= bit_cnt[5];
            i2s_sd     <= sd_next;
            frame_sync <= frame_end && pair_ok;
            underrun   <= frame_end && !pair_ok;

            if (frame_end) begin
                tail_bit <= r_aligned[0];
                if (pair_ok) begin
                    tx_l  <= stage_l;
                    tx_r  <= stage_r;
                    vld_l <= 1'b0;
                    vld_r <= 1'b0;
                end else begin
                    tx_l <= '0;
                    tx_r <= '0;
                end
            end

            // Placed after the transfer so a sample landing on the frame-end clk survives the flag clear.
            if (lim_dv) begin
                if (lim_ch) begin
                    stage_r <= lim_d;
                    vld_r   <= 1'b1;
                end else begin
                    stage_l <= lim_d;
                    vld_l   <= 1'b1;
                end
            end
        end
    end

endmodule
